// File: rtl/ro_scan_sequencer.sv
// ro_scan_sequencer: command-driven measurement sequencer for the ring-oscillator
// temperature sensor array. Decodes UART command bytes, enables one RO at a time,
// clears and gates the shared edge counter for a programmable window, latches the
// count and sends a 3-byte frame {0xA<ch>, cnt[15:8], cnt[7:0]} over UART TX.
//
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   rx_ready    - one-cycle strobe, rx_data holds a command byte
//   rx_data     - command byte: opcode [7:4], argument [3:0]
//   tx_busy     - UART transmitter busy
//   tx_send     - one-cycle strobe, transmit tx_data
//   tx_data     - byte to transmit, held until the next send
//   ro_en       - one-hot RO enable
//   cnt_clear   - one-cycle clear of the shared counter
//   cnt_gate    - shared counter enable (count window)
//   cnt_value   - shared counter value
//   busy        - high whenever the sequencer is not idle
module ro_scan_sequencer #(
   parameter int unsigned N_RO        = 4,
   parameter int unsigned SETTLE_CYC  = 32,
   parameter int unsigned WIN_EXP_RST = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_ready,
   input  logic [7:0]      rx_data,
   input  logic            tx_busy,
   output logic            tx_send,
   output logic [7:0]      tx_data,
   output logic [N_RO-1:0] ro_en,
   output logic            cnt_clear,
   output logic            cnt_gate,
   input  logic [15:0]     cnt_value,
   output logic            busy
);

   localparam int unsigned CH_W  = (N_RO > 1) ? $clog2(N_RO) : 1;
   localparam int unsigned CYC_W = 16;
   localparam logic [3:0]  W_MAX = 4'd9;

   typedef enum logic [3:0] {
      S_IDLE, S_SETTLE, S_GATE, S_LATCH,
      S_TX0, S_WAIT0, S_TX1, S_WAIT1, S_TX2, S_WAIT2,
      S_NEXT
   } state_t;

   typedef enum logic [1:0] {M_NONE, M_SCAN, M_CONT, M_SINGLE} mode_t;

   state_t             state, state_next;
   mode_t              mode, mode_next;
   logic [CH_W-1:0]    ch, ch_next;
   logic               stop_flag, stop_next;
   logic [3:0]         win_exp, win_exp_next;
   logic [CYC_W-1:0]   cyc;
   logic [15:0]        result;

   logic [N_RO-1:0]    ro_en_d;
   logic               cnt_clear_d, cnt_gate_d, tx_send_d, busy_d;
   logic [7:0]         tx_data_d;

   logic [3:0]         opcode, arg;
   logic [16:0]        win_len;
   logic [CYC_W-1:0]   win_last, settle_last;
   logic               arg_ok, ch_last, guard_done;

   assign opcode      = rx_data[7:4];
   assign arg         = rx_data[3:0];
   assign win_len     = 17'd1 << (5'd6 + {1'b0, win_exp});
   assign win_last    = CYC_W'(win_len - 17'd1);
   assign settle_last = CYC_W'(SETTLE_CYC - 1);
   assign arg_ok      = {1'b0, arg} < 5'(N_RO);
   assign ch_last     = (ch == CH_W'(N_RO - 1));
   // WAITn ignores tx_busy while the transmitter picks up the strobe
   assign guard_done  = (cyc >= CYC_W'(2));

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         mode      <= M_NONE;
         ch        <= '0;
         stop_flag <= 1'b0;
         win_exp   <= 4'(WIN_EXP_RST);
         cyc       <= '0;
         result    <= '0;
      end else begin
         state     <= state_next;
         mode      <= mode_next;
         ch        <= ch_next;
         stop_flag <= stop_next;
         win_exp   <= win_exp_next;
         cyc       <= (state_next != state || state_next == S_IDLE) ? '0 : cyc + CYC_W'(1);
         if (state == S_LATCH)
            result <= cnt_value;
      end
   end

   // Next-state, command decode and channel sequencing
   always_comb begin
      state_next   = state;
      mode_next    = mode;
      ch_next      = ch;
      stop_next    = stop_flag;
      win_exp_next = win_exp;

      // Stop is the only command honoured while busy
      if (state != S_IDLE && rx_ready && opcode == 4'h2)
         stop_next = 1'b1;

      case (state)
         S_IDLE: begin
            if (rx_ready) begin
               case (opcode)
                  4'h0: begin
                     state_next = S_SETTLE;
                     mode_next  = M_SCAN;
                     ch_next    = '0;
                     stop_next  = 1'b0;
                  end
                  4'h1: begin
                     state_next = S_SETTLE;
                     mode_next  = M_CONT;
                     ch_next    = '0;
                     stop_next  = 1'b0;
                  end
                  4'h3: begin
                     if (arg_ok) begin
                        state_next = S_SETTLE;
                        mode_next  = M_SINGLE;
                        ch_next    = CH_W'(arg);
                        stop_next  = 1'b0;
                     end
                  end
                  4'h4: win_exp_next = (arg > W_MAX) ? W_MAX : arg;
                  default: ;
               endcase
            end
         end
         S_SETTLE: if (cyc == settle_last) state_next = S_GATE;
         S_GATE:   if (cyc == win_last)    state_next = S_LATCH;
         S_LATCH:  state_next = S_TX0;
         S_TX0:    if (!tx_busy) state_next = S_WAIT0;
         S_WAIT0:  if (guard_done && !tx_busy) state_next = S_TX1;
         S_TX1:    if (!tx_busy) state_next = S_WAIT1;
         S_WAIT1:  if (guard_done && !tx_busy) state_next = S_TX2;
         S_TX2:    if (!tx_busy) state_next = S_WAIT2;
         S_WAIT2:  if (guard_done && !tx_busy) state_next = S_NEXT;
         S_NEXT: begin
            if (stop_next || mode == M_SINGLE || (mode == M_SCAN && ch_last)) begin
               state_next = S_IDLE;
            end else begin
               state_next = S_SETTLE;
               ch_next    = ch_last ? '0 : ch + CH_W'(1);
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so registered outputs align with it
   always_comb begin
      ro_en_d     = '0;
      cnt_clear_d = 1'b0;
      cnt_gate_d  = 1'b0;
      tx_send_d   = 1'b0;
      tx_data_d   = tx_data;
      busy_d      = (state_next != S_IDLE);

      if (state_next == S_SETTLE || state_next == S_GATE || state_next == S_LATCH)
         ro_en_d = N_RO'(1) << ch_next;
      cnt_clear_d = (state_next == S_SETTLE) && (state != S_SETTLE);
      cnt_gate_d  = (state_next == S_GATE);

      if (!tx_busy) begin
         case (state)
            S_TX0: begin
               tx_send_d = 1'b1;
               tx_data_d = {4'hA, 4'(ch)};
            end
            S_TX1: begin
               tx_send_d = 1'b1;
               tx_data_d = result[15:8];
            end
            S_TX2: begin
               tx_send_d = 1'b1;
               tx_data_d = result[7:0];
            end
            default: ;
         endcase
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         ro_en     <= '0;
         cnt_clear <= 1'b0;
         cnt_gate  <= 1'b0;
         tx_send   <= 1'b0;
         tx_data   <= '0;
         busy      <= 1'b0;
      end else begin
         ro_en     <= ro_en_d;
         cnt_clear <= cnt_clear_d;
         cnt_gate  <= cnt_gate_d;
         tx_send   <= tx_send_d;
         tx_data   <= tx_data_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_ro_scan_sequencer.sv
// tb_ro_scan_sequencer: randomized bench for ro_scan_sequencer with a UART busy
// model, a shared-counter model (per-RO random edge rate, saturating) and expected
// frames computed from channel, rate and window exponent.
module tb_ro_scan_sequencer;
   localparam int unsigned N_RO = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            rx_ready = 1'b0;
   logic [7:0]      rx_data = 8'h00;
   logic            tx_busy;
   logic            tx_send;
   logic [7:0]      tx_data;
   logic [N_RO-1:0] ro_en;
   logic            cnt_clear;
   logic            cnt_gate;
   logic [15:0]     cnt_value;
   logic            busy;

   always #5 clk = ~clk;

   ro_scan_sequencer #(.N_RO(N_RO), .SETTLE_CYC(32), .WIN_EXP_RST(4)) dut (
      .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
      .tx_busy(tx_busy), .tx_send(tx_send), .tx_data(tx_data), .ro_en(ro_en),
      .cnt_clear(cnt_clear), .cnt_gate(cnt_gate), .cnt_value(cnt_value), .busy(busy)
   );

   int vectors = 0;
   int miscompares = 0;

   // environment state
   int          inc [N_RO];
   logic [15:0] cnt_model = 16'h0;
   logic        model_busy = 1'b0;
   logic        force_busy = 1'b0;
   int          busy_delay = 0;
   int          busy_len = 0;
   int          ncyc = 0;
   int          send_at = -1;
   int          busy_viol = 0;
   int          gate_run = 0;
   int          en_run = 0;
   byte unsigned sent_q[$];
   byte unsigned exp_q[$];
   int          gate_q[$];
   int          en_q[$];
   int          en_ch_q[$];

   assign tx_busy   = model_busy | force_busy;
   assign cnt_value = cnt_model;

   // UART busy model, shared counter model and activity monitor
   always @(negedge clk) begin
      ncyc++;
      if (tx_send === 1'b1) begin
         sent_q.push_back(tx_data);
         if (tx_busy) busy_viol++;
         send_at = ncyc;
      end
      model_busy = (send_at >= 0) && (ncyc - send_at >= busy_delay) &&
                   (ncyc - send_at < busy_delay + busy_len);
      if (cnt_clear === 1'b1) cnt_model = 16'h0;
      else if (cnt_gate === 1'b1) begin
         for (int k = 0; k < N_RO; k++) begin
            if (ro_en[k] === 1'b1) begin
               if (int'(cnt_model) + inc[k] > 65535) cnt_model = 16'hFFFF;
               else cnt_model = 16'(int'(cnt_model) + inc[k]);
            end
         end
      end
      if (cnt_gate === 1'b1) gate_run++;
      else if (gate_run != 0) begin gate_q.push_back(gate_run); gate_run = 0; end
      if (ro_en !== '0 && !$isunknown(ro_en)) begin
         if (en_run == 0) begin
            for (int k = 0; k < N_RO; k++) if (ro_en[k]) en_ch_q.push_back(k);
         end
         en_run++;
      end else if (en_run != 0) begin en_q.push_back(en_run); en_run = 0; end
   end

   function automatic int expect_count(input int ch, input int w);
      int r;
      r = inc[ch] * (1 << (6 + w));
      return (r > 65535) ? 65535 : r;
   endfunction

   task automatic add_frame(input int ch, input int w);
      int r;
      r = expect_count(ch, w);
      exp_q.push_back(8'(8'hA0 | ch));
      exp_q.push_back(8'(r >> 8));
      exp_q.push_back(8'(r & 255));
   endtask

   task automatic clear_logs();
      sent_q.delete(); exp_q.delete(); gate_q.delete(); en_q.delete(); en_ch_q.delete();
      busy_viol = 0;
   endtask

   task automatic new_rates();
      for (int k = 0; k < N_RO; k++) inc[k] = $urandom_range(1, 3);
   endtask

   task automatic send_cmd(input logic [7:0] b);
      @(negedge clk); rx_ready = 1'b1; rx_data = b;
      @(negedge clk); rx_ready = 1'b0; rx_data = 8'($urandom);
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
      ok = (busy === 1'b0);
      @(negedge clk);
   endtask

   task automatic wait_bytes(input int cnt, input int budget, output bit ok);
      int n = 0;
      while (sent_q.size() < cnt && n < budget) begin @(negedge clk); n++; end
      ok = (sent_q.size() >= cnt);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      vectors++; if (tx_send !== 1'b0) begin miscompares++; $display("FAIL reset_tx_send: got %b want 0", tx_send); end
      vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      vectors++; if (ro_en !== '0) begin miscompares++; $display("FAIL reset_ro_en: got %b want 0", ro_en); end
      vectors++; if (cnt_clear !== 1'b0) begin miscompares++; $display("FAIL reset_cnt_clear: got %b want 0", cnt_clear); end
      vectors++; if (cnt_gate !== 1'b0) begin miscompares++; $display("FAIL reset_cnt_gate: got %b want 0", cnt_gate); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      bit ok;
      new_rates(); clear_logs();
      busy_delay = 0; busy_len = $urandom_range(0, 6);
      add_frame(1, 4);
      send_cmd(8'h31);
      wait_idle(3000, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL single_idle: busy=%b want 0", busy); end
      vectors++; if (en_q.size() != 1 || en_q[0] != 32 + 1024 + 1) begin miscompares++; $display("FAIL single_en_len: got %p want 1057", en_q); end
      vectors++; if (gate_q.size() != 1 || gate_q[0] != 1024) begin miscompares++; $display("FAIL single_gate_len: got %p want 1024", gate_q); end
      vectors++; if (en_ch_q.size() != 1 || en_ch_q[0] != 1) begin miscompares++; $display("FAIL single_channel: got %p want 1", en_ch_q); end
      vectors++; if (sent_q.size() != exp_q.size()) begin miscompares++; $display("FAIL single_nbytes: got %0d want %0d", sent_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
         vectors++; if (sent_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL single_byte%0d: got %h want %h", i, sent_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_scan();
      bit ok;
      new_rates(); clear_logs();
      busy_delay = 0; busy_len = 10;
      send_cmd(8'h42);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL setw_busy: got %b want 0", busy); end
      for (int c = 0; c < N_RO; c++) add_frame(c, 2);
      send_cmd(8'h00);
      wait_idle(8000, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL scan_idle: busy=%b want 0", busy); end
      vectors++; if (busy_viol != 0) begin miscompares++; $display("FAIL scan_send_while_busy: got %0d want 0", busy_viol); end
      vectors++; if (gate_q.size() != N_RO) begin miscompares++; $display("FAIL scan_ngates: got %0d want %0d", gate_q.size(), N_RO); end
      foreach (gate_q[i]) begin
         vectors++; if (gate_q[i] != 256) begin miscompares++; $display("FAIL scan_gate%0d: got %0d want 256", i, gate_q[i]); end
      end
      vectors++; if (sent_q.size() != exp_q.size()) begin miscompares++; $display("FAIL scan_nbytes: got %0d want %0d", sent_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
         vectors++; if (sent_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL scan_byte%0d: got %h want %h", i, sent_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_continuous_stop();
      bit ok;
      int w, n;
      int seq [6] = '{0, 1, 2, 3, 0, 1};
      new_rates(); clear_logs();
      w = $urandom_range(0, 2);
      busy_delay = $urandom_range(0, 2); busy_len = $urandom_range(0, 12);
      send_cmd(8'(8'h40 | w));
      foreach (seq[i]) add_frame(seq[i], w);
      send_cmd(8'h10);
      wait_bytes(15, 6000, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL cont_progress: got %0d bytes want 15", sent_q.size()); end
      n = 0;
      while (cnt_gate !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      vectors++; if (cnt_gate !== 1'b1) begin miscompares++; $display("FAIL cont_gate_seen: got %b want 1", cnt_gate); end
      send_cmd(8'h20);
      send_cmd(8'h31);
      wait_idle(3000, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL cont_stop_idle: busy=%b want 0", busy); end
      vectors++; if (busy_viol != 0) begin miscompares++; $display("FAIL cont_send_while_busy: got %0d want 0", busy_viol); end
      vectors++; if (sent_q.size() != exp_q.size()) begin miscompares++; $display("FAIL cont_nbytes: got %0d want %0d", sent_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
         vectors++; if (sent_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL cont_byte%0d: got %h want %h", i, sent_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_ignored_and_clamp();
      bit ok;
      int seen = 0;
      new_rates(); clear_logs();
      busy_delay = 0; busy_len = 4;
      send_cmd(8'h35);
      send_cmd(8'h7C);
      send_cmd(8'h20);
      repeat (6) begin @(negedge clk); if (busy !== 1'b0) seen++; end
      vectors++; if (seen != 0 || sent_q.size() != 0) begin miscompares++; $display("FAIL ignored_cmds: busy cycles %0d bytes %0d want 0 0", seen, sent_q.size()); end
      send_cmd(8'h4F);
      add_frame(0, 9);
      send_cmd(8'h30);
      wait_idle(40000, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL clamp_idle: busy=%b want 0", busy); end
      vectors++; if (gate_q.size() != 1 || gate_q[0] != 32768) begin miscompares++; $display("FAIL clamp_gate_len: got %p want 32768", gate_q); end
      vectors++; if (sent_q.size() != exp_q.size()) begin miscompares++; $display("FAIL clamp_nbytes: got %0d want %0d", sent_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
         vectors++; if (sent_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL clamp_byte%0d: got %h want %h", i, sent_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_abort();
      bit ok;
      new_rates(); clear_logs();
      busy_delay = 0; busy_len = 0;
      send_cmd(8'h42);
      send_cmd(8'h00);
      repeat (4) @(negedge clk);
      send_cmd(8'h31);
      wait_bytes(1, 2000, ok);
      force_busy = 1'b1;
      vectors++; if (!ok) begin miscompares++; $display("FAIL abort_first_byte: got %0d bytes want 1", sent_q.size()); end
      repeat (5) @(negedge clk);
      vectors++; if (sent_q.size() != 1 || sent_q[0] !== 8'hA0) begin miscompares++; $display("FAIL abort_header: got %p want A0 only", sent_q); end
      vectors++; if (ro_en !== '0) begin miscompares++; $display("FAIL abort_ro_en_tx: got %b want 0", ro_en); end
      force_busy = 1'b0;
      @(negedge clk);
      force_busy = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      vectors++; if ({tx_send, ro_en, cnt_clear, cnt_gate, busy} !== '0) begin
         miscompares++; $display("FAIL abort_outputs: send %b en %b clr %b gate %b busy %b want all 0", tx_send, ro_en, cnt_clear, cnt_gate, busy);
      end
      vectors++; if (sent_q.size() != 1) begin miscompares++; $display("FAIL abort_partial_frame: got %0d bytes want 1", sent_q.size()); end
      @(negedge clk);
      reset = 1'b0; force_busy = 1'b0;
      clear_logs();
      add_frame(0, 4);
      send_cmd(8'h30);
      wait_idle(3000, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL abort_rerun_idle: busy=%b want 0", busy); end
      vectors++; if (gate_q.size() != 1 || gate_q[0] != 1024) begin miscompares++; $display("FAIL abort_w_restored: got %p want 1024", gate_q); end
      vectors++; if (sent_q.size() != exp_q.size()) begin miscompares++; $display("FAIL abort_nbytes: got %0d want %0d", sent_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
         vectors++; if (sent_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL abort_byte%0d: got %h want %h", i, sent_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int w, ch;
      new_rates(); clear_logs();
      w = $urandom_range(0, 1);
      busy_delay = 2; busy_len = $urandom_range(1, 8);
      send_cmd(8'(8'h40 | w));
      for (int c = 0; c < N_RO; c++) add_frame(c, w);
      send_cmd(8'h00);
      wait_idle(5000, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_scan_idle: busy=%b want 0", busy); end
      busy_delay = 1;
      ch = $urandom_range(0, N_RO - 1);
      add_frame(ch, w);
      send_cmd(8'(8'h30 | ch));
      wait_idle(2000, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_single_idle: busy=%b want 0", busy); end
      vectors++; if (busy_viol != 0) begin miscompares++; $display("FAIL b2b_send_while_busy: got %0d want 0", busy_viol); end
      vectors++; if (sent_q.size() != 3 * (N_RO + 1)) begin miscompares++; $display("FAIL b2b_send_count: got %0d want %0d", sent_q.size(), 3 * (N_RO + 1)); end
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
         vectors++; if (sent_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_byte%0d: got %h want %h", i, sent_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      new_rates();
      test_reset();
      test_single();
      test_scan();
      test_continuous_stop();
      test_ignored_and_clamp();
      test_reset_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors %0d miscompares", vectors, miscompares);
      $fatal(1, "watchdog");
   end

endmodule
